// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - ring-counter health monitor and position decoder
// Optional saturating error counter (err_cnt_o) is compiled in with RING_MON_ERRCNT_EN.
module ring_monitor #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int LAP_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [WIDTH-1:0]         q_in_i,
  input  logic                     clr_err_i,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic                     onehot_o,
  output logic                     locked_o,
  output logic                     lap_pulse_o,
  output logic [LAP_W-1:0]         lap_cnt_o,
  output logic                     err_o,
`ifdef RING_MON_ERRCNT_EN
  output logic [7:0]               err_cnt_o,
`endif
  output logic                     err_sticky_o
);

  localparam int PW = $clog2(WIDTH);
  localparam int GW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_N - 1);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  state_t           state_q;
  logic [GW-1:0]    good_cnt_q;
  logic [WIDTH-1:0] prev_q;
  logic [PW-1:0]    pos_q;
  logic             onehot_q;
  logic             lap_pulse_q;
  logic [LAP_W-1:0] lap_cnt_q;
  logic             err_q;
  logic             err_sticky_q;

  logic             is_onehot;
  logic             match;
  logic [WIDTH-1:0] rotl_prev;
  logic [PW-1:0]    pos_d;

  // Classify the incoming sample and decode the set bit's index
  always_comb begin
    is_onehot = (q_in_i != '0) && ((q_in_i & (q_in_i - WIDTH'(1))) == '0);
    rotl_prev = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    match     = is_onehot && (q_in_i == rotl_prev);
    pos_d     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_in_i[i]) pos_d = PW'(i);
    end
  end

  // Lock FSM with registered outputs; a new error overrides clr_err on err_sticky
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= HUNT;
      good_cnt_q   <= '0;
      prev_q       <= '0;
      pos_q        <= '0;
      onehot_q     <= 1'b0;
      lap_pulse_q  <= 1'b0;
      lap_cnt_q    <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      lap_pulse_q <= 1'b0;
      if (clr_err_i) err_sticky_q <= 1'b0;
      if (en_i) begin
        onehot_q <= is_onehot;
        if (is_onehot) begin
          prev_q <= q_in_i;
          pos_q  <= pos_d;
        end
        case (state_q)
          HUNT: begin
            if (is_onehot) begin
              state_q    <= ACQ;
              good_cnt_q <= '0;
            end
          end
          ACQ: begin
            if (match) begin
              if (good_cnt_q == GOOD_LAST) state_q <= LOCKED;
              else good_cnt_q <= good_cnt_q + GW'(1);
            end else if (is_onehot) begin
              good_cnt_q <= '0;
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            if (match) begin
              if (q_in_i[0]) begin
                lap_pulse_q <= 1'b1;
                lap_cnt_q   <= lap_cnt_q + LAP_W'(1);
              end
            end else begin
              err_q        <= 1'b1;
              err_sticky_q <= 1'b1;
              good_cnt_q   <= '0;
              state_q      <= is_onehot ? ACQ : HUNT;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

`ifdef RING_MON_ERRCNT_EN
  logic       err_event;
  logic [7:0] err_cnt_q;

  assign err_event = en_i && (state_q == LOCKED) && !match;

  // Saturating error count; clear and a same-cycle error leave it at 1
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_q <= '0;
    end else if (clr_err_i) begin
      err_cnt_q <= err_event ? 8'd1 : 8'd0;
    end else if (err_event && err_cnt_q != 8'hff) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign pos_o        = pos_q;
  assign onehot_o     = onehot_q;
  assign locked_o     = (state_q == LOCKED);
  assign lap_pulse_o  = lap_pulse_q;
  assign lap_cnt_o    = lap_cnt_q;
  assign err_o        = err_q;
  assign err_sticky_o = err_sticky_q;

endmodule
